// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states,
// default operand width and the bit-counter width helper.
package serial_addsub_pkg;

  // Operand/result width used when the instantiating code does not override it.
  localparam int WIDTH_DEFAULT = 8;

  // Sequencer states: waiting, shifting one bit per clock, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Bit counter width: ceil(log2(width)), never less than one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are captured on START, then one bit
// per clock is pushed LSB first through a single full adder and a carry flop.
// The result, carry-out and overflow appear together with a one-cycle DONE.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DO,
  output logic             CO,
  output logic             OV
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Sequencer state
  state_e state_q, state_d;

  // Operand shift registers (LSB presented at bit 0) and captured controls
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;

  // Partial result: holds result bits 0..WIDTH-2 after the last shift, so
  // the MSB is taken straight from the adder when the result is published.
  logic [WIDTH-2:0] res_q, res_d;

  // Serial carry and bit counter
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Published result and status
  logic [WIDTH-1:0] do_q, do_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Combinational helpers
  logic capture_s;
  logic last_bit_s;
  logic fa_a_s;
  logic fa_b_s;
  logic fa_s_s;
  logic fa_co_s;

  // New operands are taken whenever the block can accept work and START is high.
  assign capture_s  = START && ((state_q == IDLE) || (state_q == FIN));
  assign last_bit_s = (cnt_q == CNT_LAST);

  // B is stored unmodified; the invert control is applied bit by bit.
  assign fa_a_s = a_q[0];
  assign fa_b_s = b_q[0] ^ sub_q;

  full_adder u_fa (
    .a  (fa_a_s),
    .b  (fa_b_s),
    .ci (carry_q),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // Next-state logic: IDLE waits for START, RUN counts bits, FIN lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        if (START) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  // Datapath: load on capture, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    do_d    = do_q;
    co_d    = co_q;
    ov_d    = ov_q;
    if (capture_s) begin
      a_d     = A;
      b_d     = B;
      sub_d   = SUB;
      carry_d = CIN;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == RUN) begin
      a_d              = a_q >> 1'b1;
      b_d              = b_q >> 1'b1;
      res_d            = res_q >> 1'b1;
      res_d[WIDTH-2]   = fa_s_s;
      carry_d          = fa_co_s;
      if (last_bit_s) begin
        // Counter parks at the last index; it is reloaded on the next capture.
        cnt_d = cnt_q;
        do_d  = {fa_s_s, res_q};
        co_d  = fa_co_s;
        ov_d  = fa_co_s ^ carry_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      a_d   = a_q;
      b_d   = b_q;
      cnt_d = cnt_q;
    end
  end

  // State and datapath registers; reset overrides any operation in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      do_q    <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DO   = do_q;
  assign CO   = co_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH = 2, 8 and 32. Each width has
// its own stimulus process pushing expected results and a monitor that pops
// and compares whenever DONE is seen.
module tb_serial_addsub;

  typedef struct {
    logic [31:0] res;
    bit          co;
    bit          ov;
    longint      done_edge;
  } exp_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: unsigned sum gives result and carry, the
  // signed interpretation of the same operands gives overflow.
  function automatic void ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                    input bit sub, input bit cin,
                                    output logic [31:0] res, output bit co, output bit ov);
    longint unsigned span;
    longint unsigned bb;
    longint unsigned total;
    longint          sa;
    longint          sb;
    longint          ssum;
    span  = 64'd1 << w;
    bb    = sub ? (span - 64'd1 - b) : b;
    total = a + bb + 64'(cin);
    res   = 32'(total % span);
    co    = (total >= span);
    sa    = (a  >= span / 2) ? longint'(a)  - longint'(span) : longint'(a);
    sb    = (bb >= span / 2) ? longint'(bb) - longint'(span) : longint'(bb);
    ssum  = sa + sb + longint'(cin);
    ov    = (ssum >= longint'(span / 2)) || (ssum < -longint'(span / 2));
  endfunction

  function automatic int w_of(input int i);
    case (i)
      0:       return 2;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = w_of(gi);

    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         co;
    logic         ov;

    exp_t        q[$];
    logic [31:0] hold_res = 32'd0;
    bit          hold_co  = 1'b0;
    bit          hold_ov  = 1'b0;
    bit          mon_en   = 1'b0;
    bit          fin_b    = 1'b0;

    serial_addsub #(.WIDTH(W)) u_dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .SUB   (sub),
      .CIN   (cin),
      .A     (a),
      .B     (b),
      .BUSY  (busy),
      .DONE  (done),
      .DO    (dout),
      .CO    (co),
      .OV    (ov)
    );

    // Monitor: on DONE compare against the oldest expectation, otherwise the
    // outputs must still show the last published result.
    always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
        if (done) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL w%0d unexpected_done: got DONE=1 at edge %0d, want no DONE", W, cyc + 1);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d do", W), 64'(dout), 64'(e.res[W-1:0]));
            chk($sformatf("w%0d co", W), 64'(co), 64'(e.co));
            chk($sformatf("w%0d ov", W), 64'(ov), 64'(e.ov));
            chk($sformatf("w%0d done_edge", W), 64'(cyc + 1), 64'(e.done_edge));
            hold_res = e.res;
            hold_co  = e.co;
            hold_ov  = e.ov;
          end
        end else begin
          chk($sformatf("w%0d hold_do", W), 64'(dout), 64'(hold_res[W-1:0]));
          chk($sformatf("w%0d hold_co", W), 64'(co), 64'(hold_co));
          chk($sformatf("w%0d hold_ov", W), 64'(ov), 64'(hold_ov));
        end
      end
    end

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Issue one operation; called just after an edge with the DUT in IDLE or
    // FIN. mode: 0 START low during RUN, 1 random START pulses, 2 held high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbo,
                          input bit tsub, input bit tcin, input int mode);
      exp_t   e;
      longint s_edge;
      ref_model(W, 64'(ta), 64'(tbo), tsub, tcin, e.res, e.co, e.ov);
      a      = ta;
      b      = tbo;
      sub    = tsub;
      cin    = tcin;
      start  = 1'b1;
      s_edge = cyc + 1;
      // DONE must be sampled high by the edge WIDTH+1 after the capture edge.
      e.done_edge = s_edge + W + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      for (int i = 0; i < W; i++) begin
        chk($sformatf("w%0d busy_run", W), 64'(busy), 64'd1);
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        start = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'($urandom) : 1'b0);
        @(posedge clk);
        #1;
      end
      chk($sformatf("w%0d busy_fin", W), 64'(busy), 64'd0);
      start = 1'b0;
    endtask

    // Stimulus for this width.
    initial begin
      logic [W-1:0] all1;
      logic [W-1:0] maxpos;
      logic [W-1:0] minneg;
      logic [W-1:0] one;
      all1      = '1;
      maxpos    = '1;
      maxpos[W-1] = 1'b0;
      minneg    = '0;
      minneg[W-1] = 1'b1;
      one       = W'(1);
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;
      idle(2);
      chk($sformatf("w%0d rst_busy", W), 64'(busy), 64'd0);
      chk($sformatf("w%0d rst_done", W), 64'(done), 64'd0);
      chk($sformatf("w%0d rst_do", W), 64'(dout), 64'd0);
      chk($sformatf("w%0d rst_co", W), 64'(co), 64'd0);
      chk($sformatf("w%0d rst_ov", W), 64'(ov), 64'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Directed vectors, then width extremes.
      run_op(W'(32'h3C), W'(32'h05), 1'b0, 1'b0, 0);
      idle(1);
      run_op(W'(32'h05), W'(32'h07), 1'b1, 1'b1, 0);
      idle(2);
      run_op(W'(32'h7F), W'(32'h01), 1'b0, 1'b0, 0);
      run_op(W'(32'hFF), W'(32'h00), 1'b0, 1'b1, 0);
      idle(1);
      run_op(maxpos, one, 1'b0, 1'b0, 0);
      run_op(all1, '0, 1'b0, 1'b1, 0);
      run_op(minneg, one, 1'b1, 1'b1, 0);
      run_op(all1, all1, 1'b0, 1'b1, 0);
      idle(1);

      // Back-to-back with START held high, then with stray START pulses.
      for (int i = 0; i < 6; i++) begin
        run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 2);
      end
      idle(1);
      for (int i = 0; i < 4; i++) begin
        run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
      end
      idle(2);

      // Abort mid-operation with reset: no DONE, outputs cleared.
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'b0;
      cin   = 1'b1;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(W / 2);
      rst = 1'b1;
      idle(1);
      hold_res = 32'd0;
      hold_co  = 1'b0;
      hold_ov  = 1'b0;
      chk($sformatf("w%0d abort_busy", W), 64'(busy), 64'd0);
      chk($sformatf("w%0d abort_done", W), 64'(done), 64'd0);
      chk($sformatf("w%0d abort_do", W), 64'(dout), 64'd0);
      chk($sformatf("w%0d abort_co", W), 64'(co), 64'd0);
      chk($sformatf("w%0d abort_ov", W), 64'(ov), 64'd0);
      rst = 1'b0;
      // First START right on the edge after reset is released.
      run_op(W'(32'h3C), W'(32'h05), 1'b0, 1'b0, 0);
      idle(W + 3);

      // Randomised operations with random gaps and START behaviour.
      for (int i = 0; i < 30; i++) begin
        run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        idle(int'($urandom_range(0, 2)));
      end
      idle(3);
      chk($sformatf("w%0d pending", W), 64'(q.size()), 64'd0);
      fin_b = 1'b1;
    end
  end

  // Wait for all widths to finish, bounded, then report.
  initial begin
    int guard;
    guard = 0;
    while (!(g_w[0].fin_b && g_w[1].fin_b && g_w[2].fin_b) && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 50000) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no completion after %0d cycles, want completion", guard);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request; sampled on a rising edge when the block is not busy.
REQ-005 SUB  input  1  operand-B invert control, captured with START.
REQ-006 CIN  input  1  carry-in into bit 0, captured with START.
REQ-007 A  input  WIDTH  operand A, captured with START.
REQ-008 B  input  WIDTH  operand B, captured with START.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  single-cycle pulse marking result valid.
REQ-011 DO  output  WIDTH  result.
REQ-012 CO  output  1  carry out of MSB.
REQ-013 OV  output  1  two's-complement overflow.
REQ-014 Clock port CLK; reset port RST is synchronous and active-high.

Function
REQ-015 Result SHALL equal A + (B XOR {WIDTH{SUB}}) + CIN, truncated to WIDTH bits; CO is the bit-WIDTH carry.
REQ-016 OV SHALL equal carry into MSB XOR carry out of MSB.
REQ-017 Computation SHALL be bit-serial, LSB first, one bit per clock, through a single one-bit full adder plus a carry flip-flop.
REQ-018 FSM states: IDLE, RUN, FIN.
REQ-019 IDLE: START=1 captures A, B, SUB, CIN, loads carry with CIN, clears bit counter, goes to RUN; else stays.
REQ-020 RUN: one bit per cycle; after bit WIDTH-1 is processed, goes to FIN.
REQ-021 FIN: lasts one cycle; DONE=1; DO/CO/OV update to the new result on entry; next state RUN if START=1 (back-to-back, operands captured), else IDLE.
REQ-022 Latency: DONE high exactly WIDTH+1 cycles after the edge that sampled START.
REQ-023 BUSY=1 in RUN only; START during RUN SHALL be ignored, captured operands unchanged.
REQ-024 DO, CO, OV SHALL hold the previous result throughout RUN and IDLE, changing only on entry to FIN.
REQ-025 Input changes on A, B, SUB, CIN after capture SHALL not affect the result.
REQ-026 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and never wrap within one operation.

Reset
REQ-027 RST=1 at a rising edge SHALL force state IDLE, BUSY=0, DONE=0, DO=0, CO=0, OV=0, carry and counter cleared.
REQ-028 RST SHALL take priority over START and over an operation in progress; an aborted operation SHALL produce no DONE.
REQ-029 First START SHALL be accepted on the first edge after RST deasserts.

Structure
REQ-030 Package serial_addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, FIN) and the WIDTH default constant.
REQ-031 One sub-module full_adder (inputs a, b, ci; outputs s, co) SHALL implement the per-bit sum; instantiated once.
REQ-032 Operand/result shift registers, carry flop, counter and FSM SHALL reside in serial_addsub.

Verification (WIDTH=8)
REQ-033 A=0x3C, B=0x05, SUB=0, CIN=0 -> DO=0x41, CO=0, OV=0, DONE at 9 cycles after START.
REQ-034 A=0x05, B=0x07, SUB=1, CIN=1 -> DO=0xFE, CO=0, OV=0; A=0x7F, B=0x01, ADD -> DO=0x80, CO=0, OV=1.
REQ-035 A=0xFF, B=0x00, SUB=0, CIN=1 -> DO=0x00, CO=1, OV=0.
REQ-036 START held high continuously with new operands each FIN -> DONE every 9 cycles, each result correct; START pulses during RUN ignored.
REQ-037 RST asserted at bit 4 of an operation -> no DONE, all outputs 0, IDLE; following START completes correctly.
REQ-038 Randomised operands across WIDTH=2, 8, 32 checked against reference model of REQ-015/016.
